// File: rtl/siso_pkg.sv
// Shared types and line-level constants for the framed serial link.
// No ports: provides the framer FSM state enum, the line levels used on
// serial_out, and a helper that sizes the data-bit counter.
package siso_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_e;

   localparam logic IDLE_LEVEL = 1'b1;
   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;

   // Bits needed to hold an index 0..w-1 (w >= 2).
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/siso_bit_counter.sv
// Data-bit index counter for the framer.
// Ports:
//   clk, rst  : clock and asynchronous active-low reset
//   i_clr     : synchronous clear to 0 (wins over i_en)
//   i_en      : advance by one; holds at LAST instead of wrapping
//   o_tc_c    : combinational terminal count, count == LAST
module siso_bit_counter #(
   parameter int unsigned CNT_W = 2,
   parameter int unsigned LAST  = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc_c
);

   logic [CNT_W-1:0] r_count;
   logic             w_tc;

   assign w_tc   = (r_count == CNT_W'(LAST));
   assign o_tc_c = w_tc;

   // Saturating count so the index never wraps while a frame is in DATA.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en && !w_tc) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/piso_framer.sv
// Parallel-in serial-out framer: start bit, WIDTH data bits LSB first,
// optional even-parity bit, stop bit.
// Ports:
//   clk, rst      : clock and asynchronous active-low reset (rst is expected
//                   to be released synchronously to clk by the reset source)
//   par_in        : payload word, captured when in_valid && in_ready
//   in_valid      : par_in holds a word to send
//   in_ready      : block accepts a word this cycle (IDLE and STOP)
//   serial_out    : framed serial stream, idles high
//   frame_active  : a frame is on serial_out
//   frame_done    : one-cycle pulse while the stop bit is driven
module piso_framer
   import siso_pkg::*;
#(
   parameter int unsigned WIDTH     = 4,
   parameter bit          PARITY_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] par_in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             serial_out,
   output logic             frame_active,
   output logic             frame_done
);

   localparam int unsigned CNT_W = cnt_width(WIDTH);

   state_e           r_state;
   logic [WIDTH-1:0] r_shift;
   logic             r_parity;
   logic             r_serial;
   logic             r_ready;
   logic             r_active;
   logic             r_done;

   logic             w_xfer;
   logic             w_cnt_clr;
   logic             w_cnt_en;
   logic             w_tc;

   assign w_xfer    = in_valid && r_ready;
   // Clearing during START makes the count 0 on the first DATA cycle.
   assign w_cnt_clr = (r_state == START);
   assign w_cnt_en  = (r_state == DATA);

   siso_bit_counter #(
      .CNT_W (CNT_W),
      .LAST  (WIDTH - 1)
   ) u_bit_counter (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_cnt_clr),
      .i_en   (w_cnt_en),
      .o_tc_c (w_tc)
   );

   // Frame FSM; every output is registered alongside the state so each
   // bit appears on serial_out in the same cycle its state is entered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= IDLE;
         r_shift  <= '0;
         r_parity <= 1'b0;
         r_serial <= IDLE_LEVEL;
         r_ready  <= 1'b0;
         r_active <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE, STOP: begin
               if (w_xfer) begin
                  r_state  <= START;
                  r_shift  <= par_in;
                  r_parity <= ^par_in;
                  r_serial <= START_BIT;
                  r_active <= 1'b1;
                  r_ready  <= 1'b0;
               end else begin
                  r_state  <= IDLE;
                  r_serial <= IDLE_LEVEL;
                  r_active <= 1'b0;
                  r_ready  <= 1'b1;
               end
            end
            START: begin
               r_state  <= DATA;
               r_serial <= r_shift[0];
               r_shift  <= r_shift >> 1;
            end
            DATA: begin
               if (w_tc) begin
                  if (PARITY_EN) begin
                     r_state  <= PARITY;
                     r_serial <= r_parity;
                  end else begin
                     r_state  <= STOP;
                     r_serial <= STOP_BIT;
                     r_done   <= 1'b1;
                     r_ready  <= 1'b1;
                  end
               end else begin
                  r_serial <= r_shift[0];
                  r_shift  <= r_shift >> 1;
               end
            end
            PARITY: begin
               r_state  <= STOP;
               r_serial <= STOP_BIT;
               r_done   <= 1'b1;
               r_ready  <= 1'b1;
            end
            default: begin
               r_state  <= IDLE;
               r_serial <= IDLE_LEVEL;
               r_active <= 1'b0;
               r_ready  <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready     = r_ready;
   assign serial_out   = r_serial;
   assign frame_active = r_active;
   assign frame_done   = r_done;

endmodule
